// File: rtl/rede_pkg.sv
// Shared constants and types for the rede I/O sequencer.
// Request/valid codes mirror the rede core's 4-bit handshake encoding.
package rede_pkg;
  localparam int DW_DEF = 31;

  localparam logic [3:0] REQ_SAMPLE = 4'd1;
  localparam logic [3:0] OUT_VALID  = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/rede_sfifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
// A push while full is taken only when a pop frees the slot in the same cycle.
module rede_sfifo #(
  parameter int DW    = 31,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp, rp;
  logic          wr, rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rede_io_ctrl.sv
// Streaming sequencer between an upstream sample source, the rede core and a
// downstream result sink; frames runs with start/stop and tracks traffic/errors.
module rede_io_ctrl
  import rede_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int IDEPTH = 16,
  parameter int ODEPTH = 16,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          clr_err,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] net_in,
  input  logic [3:0]    net_req,
  input  logic [DW-1:0] net_out,
  input  logic [3:0]    net_out_en,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          underrun,
  output logic          overflow,
  output logic [CW-1:0] in_cnt,
  output logic [CW-1:0] out_cnt
);
  state_t state, state_n;
  logic   pop_en, cap_en;

  logic          in_full, in_empty, in_push, in_pop;
  logic [DW-1:0] in_dout;
  logic          out_full, out_empty, out_push, out_pop, cap;
  logic          under_set, over_set;

  rede_sfifo #(.DW(DW), .DEPTH(IDEPTH)) u_ififo (
    .clk(clk), .rst(rst),
    .push(in_push), .din(s_data),
    .pop(in_pop), .dout(in_dout),
    .full(in_full), .empty(in_empty)
  );

  rede_sfifo #(.DW(DW), .DEPTH(ODEPTH)) u_ofifo (
    .clk(clk), .rst(rst),
    .push(out_push), .din(net_out),
    .pop(out_pop), .dout(m_data),
    .full(out_full), .empty(out_empty)
  );

  assign s_ready = !in_full;
  assign m_valid = !out_empty;
  assign in_push = s_valid && s_ready;
  assign out_pop = m_valid && m_ready;

  assign in_pop    = pop_en && (net_req == REQ_SAMPLE) && !in_empty;
  assign under_set = pop_en && (net_req == REQ_SAMPLE) && in_empty;

  // A full output FIFO still accepts a result if the head leaves this cycle.
  assign cap      = cap_en && (net_out_en == OUT_VALID);
  assign out_push = cap && (!out_full || out_pop);
  assign over_set = cap && out_full && !out_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (stop)  state_n = ST_DRAIN;
      ST_DRAIN: if (out_empty && (net_out_en != OUT_VALID)) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    pop_en = (state == ST_RUN);
    cap_en = (state == ST_RUN) || (state == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      net_in   <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      if (in_pop) net_in <= in_dout;

      if (under_set)    underrun <= 1'b1;
      else if (clr_err) underrun <= 1'b0;
      if (over_set)     overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;

      // Counters restart at each run start; no traffic can occur on that edge.
      if (state == ST_IDLE && start) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_pop && in_cnt != '1)    in_cnt  <= in_cnt + 1'b1;
        if (out_push && out_cnt != '1) out_cnt <= out_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rede_io_ctrl.sv
// Scoreboard bench: stimulus queues expected net_in / m_data values,
// an independent monitor compares them as the DUT presents them.
module tb_rede_io_ctrl;
  localparam int DW = 31;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, clr_err, s_valid, m_ready;
  logic [DW-1:0] s_data, net_out, net_in, m_data;
  logic [3:0]    net_req, net_out_en;
  logic          s_ready, m_valid, busy, underrun, overflow;
  logic [CW-1:0] in_cnt, out_cnt;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_net[$];
  logic [DW-1:0] exp_m[$];
  logic          req_seen = 1'b0;

  rede_io_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_err(clr_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .net_in(net_in), .net_req(net_req), .net_out(net_out), .net_out_en(net_out_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .underrun(underrun), .overflow(overflow),
    .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sv(int x);
    return x[DW-1:0];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(int v);
    s_valid = 1'b1; s_data = sv(v);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic req(int expv);
    exp_net.push_back(sv(expv));
    net_req = 4'd1;
    tick();
    net_req = 4'd0;
  endtask

  task automatic result(int v, bit expect_out);
    if (expect_out) exp_m.push_back(sv(v));
    net_out_en = 4'd1; net_out = sv(v);
    tick();
    net_out_en = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Monitor: net_in is due the cycle after a request; m_data on each handshake.
  always @(posedge clk) req_seen <= rst && (net_req == 4'd1);

  always @(negedge clk) begin
    if (req_seen) begin
      if (exp_net.size() == 0) chk("net_in_unexpected", 64'(net_in), 64'hdead);
      else chk("net_in", 64'(net_in), 64'(exp_net.pop_front()));
    end
    if (rst && m_valid && m_ready) begin
      if (exp_m.size() == 0) chk("m_data_unexpected", 64'(m_data), 64'hdead);
      else chk("m_data", 64'(m_data), 64'(exp_m.pop_front()));
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clr_err = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    net_req = 4'd0; net_out = '0; net_out_en = 4'd0;
    repeat (2) tick();

    chk("rst_s_ready", 64'(s_ready), 1);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_net_in", 64'(net_in), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_flags", {62'd0, underrun, overflow}, 0);
    chk("rst_cnts", {32'd0, in_cnt, out_cnt}, 0);
    rst = 1'b1;
    tick();

    // Basic flow
    push_in(3); push_in(-5); push_in(7);
    req(0);                       // ignored in IDLE; net_in holds reset value
    pulse_start();
    chk("run_busy", 64'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      req(i == 0 ? 3 : (i == 1 ? -5 : 7));
      repeat (3) tick();
    end
    chk("basic_in_cnt", 64'(in_cnt), 3);

    // Underrun; set wins over a same-cycle clear
    clr_err = 1'b1;
    req(7);
    clr_err = 1'b0;
    tick();
    chk("underrun_set", 64'(underrun), 1);
    chk("underrun_in_cnt", 64'(in_cnt), 3);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("underrun_clr", 64'(underrun), 0);

    // Overflow on the 17th result
    for (int i = 0; i < 17; i++) result(i, i < 16);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_out_cnt", 64'(out_cnt), 16);
    chk("ovf_m_valid", 64'(m_valid), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clr", 64'(overflow), 0);

    // Full FIFO with same-cycle pop accepts the push
    m_ready = 1'b1;
    result(100, 1'b1);
    m_ready = 1'b0;
    chk("fullpop_no_ovf", 64'(overflow), 0);
    chk("fullpop_out_cnt", 64'(out_cnt), 17);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && m_valid; i++) tick();
    m_ready = 1'b0;
    chk("fullpop_drained", 64'(exp_m.size()), 0);

    // Drain: stop with 4 results queued and 2 samples still buffered
    for (int i = 0; i < 4; i++) result(200 + i, 1'b1);
    push_in(11); push_in(22);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_busy", 64'(busy), 1);
    req(7);                       // no pop in DRAIN
    tick();
    chk("drain_in_cnt", 64'(in_cnt), 3);
    chk("drain_still_busy", 64'(busy), 1);
    m_ready = 1'b1;
    for (int i = 0; i < 30 && busy; i++) tick();
    m_ready = 1'b0;
    chk("drain_idle", 64'(busy), 0);
    chk("drain_m_valid", 64'(m_valid), 0);
    chk("drain_results", 64'(exp_m.size()), 0);

    // Restart clears counters; buffered samples survive the idle period
    pulse_start();
    chk("restart_cnts", {32'd0, in_cnt, out_cnt}, 0);
    req(11);
    tick();
    chk("restart_in_cnt", 64'(in_cnt), 1);
    result(300, 1'b0);
    chk("pre_rst_m_valid", 64'(m_valid), 1);

    // Mid-run reset discards everything
    rst = 1'b0;
    #2;
    chk("midrst_m_valid", 64'(m_valid), 0);
    chk("midrst_s_ready", 64'(s_ready), 1);
    chk("midrst_net_in", 64'(net_in), 0);
    chk("midrst_cnts", {32'd0, in_cnt, out_cnt}, 0);
    chk("midrst_busy", 64'(busy), 0);
    tick();
    rst = 1'b1;
    tick();

    // Input FIFO fills at 16 and backpressures
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = sv(i); tick();
    end
    chk("in_full_s_ready", 64'(s_ready), 0);
    s_valid = 1'b0;
    tick();

    chk("net_queue_empty", 64'(exp_net.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
